mul_datapath: RTL
=================

Name: mul_datapath

Overview:
- Datapath for the repeated-addition multiplier, driven by the multiplier control unit.
- It consumes the CU's control strobes (L_R1..L_R4, R_R3, Dec_R1, Sel_R1, Sel_R2, S_R, R_R) and returns the status bits the CU branches on (OR_R1, CMP_L_R1).
- It holds the operand, counter, accumulator and result registers and drives the product and ready flag to the top level.

Parameters:
- WIDTH, 8, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk
- A  input  WIDTH  multiplicand operand
- B  input  WIDTH  multiplier operand
- L_R1  input  1  load R1 from the mux selected by Sel_R1
- L_R2  input  1  load R2 from the mux selected by Sel_R2
- L_R3  input  1  accumulate: R3 <= R3 + zero-extended R2
- L_R4  input  1  load result register: R4 <= R3
- R_R3  input  1  clear R3
- Dec_R1  input  1  R1 <= R1 - 1
- Sel_R1  input  1  R1 source: 0 = A, 1 = R2
- Sel_R2  input  1  R2 source: 0 = B, 1 = R1
- S_R  input  1  set ready flag
- R_R  input  1  reset ready flag
- OR_R1  output  1  reduction-OR of R1 (R1 != 0)
- CMP_L_R1  output  1  1 when R1 <= R2 (unsigned)
- product  output  2*WIDTH  R4 contents
- ready  output  1  ready flag register

Behaviour:
- Reset: when rst=0 at a rising edge, R1=0, R2=0, R3=0, R4=0 and ready=0 on the next cycle.
  - Outputs in reset: product=0, ready=0, OR_R1=0, CMP_L_R1=1.
  - Reset overrides every strobe, including mid-accumulation.
- Register updates: all registers update only on the rising edge.
- Status outputs: OR_R1 and CMP_L_R1 are combinational from registered R1/R2 only, never from inputs. They are valid in the cycle after the load edge, which is zero extra latency for the CU.
- R1 priority: L_R1 over Dec_R1.
  - Dec_R1 with R1=0 holds R1 at 0 (no wrap).
- Swap: L_R1=L_R2=1 with Sel_R1=Sel_R2=1 exchanges R1 and R2 in one edge, using pre-edge values.
  - Mixed selects are legal and use pre-edge values; e.g. Sel_R1=1, Sel_R2=0 gives R1<=old R2, R2<=B.
- R3 priority: R_R3 over L_R3.
  - Accumulation is 2*WIDTH bits wide, with R2 zero-extended. Overflow cannot occur when iterations ≤ R1's initial value.
  - If overflow is forced, the sum wraps modulo 2^(2*WIDTH).
- R4: loads R3 on L_R4, otherwise holds. L_R4 with L_R3 in the same cycle loads the pre-edge R3.
- ready: R_R has priority over S_R (both asserted → 0); otherwise ready holds.
- Independent strobes (different registers) asserted in the same cycle all take effect on that edge.
- Intended CU sequence (informative):
  - init: load A/B, clear R3.
  - cmp: swap when CMP_L_R1=0, so R1 holds the smaller operand.
  - mul: L_R3 + Dec_R1 each cycle while OR_R1=1; then L_R4 and S_R.

Decomposition:
- Shared package mul_pkg holds:
  - DEFAULT_WIDTH = 8;
  - select encodings SEL_EXT = 1'b0 and SEL_XCHG = 1'b1, shared with the CU;
  - a localparam for product width (2*WIDTH).
- One natural sub-module, dp_reg: parameterised width, synchronous active-low reset, with clear, load and hold.
  - Instantiated for R2, R3, R4.
  - R1 carries its own load/decrement logic inline.

Test Plan (WIDTH=8):
- Reset: rst=0 for 1 cycle with all strobes high → R1..R4=0, product=0, ready=0, OR_R1=0, CMP_L_R1=1.
- Load then swap:
  - A=5, B=3, L_R1=L_R2=1, Sel=0 → R1=5, R2=3, CMP_L_R1=0, OR_R1=1.
  - Next cycle Sel_R1=Sel_R2=1 with both loads → R1=3, R2=5, CMP_L_R1=1.
- Multiply 3×5:
  - R_R3, then 3 cycles of L_R3+Dec_R1 → R3=15, R1=0, OR_R1=0.
  - Then L_R4 → product=15; then S_R → ready=1.
- Max operands: A=B=255, full sequence (255 accumulate cycles) → product=65025, no wrap.
- Priority cases:
  - L_R3+R_R3 → R3=0.
  - S_R+R_R → ready=0.
  - Dec_R1 at R1=0 → R1 stays 0.
  - L_R1(A=9)+Dec_R1 → R1=9.
  - L_R4+L_R3 with R3=10, R2=5 → R4=10, R3=15.
- Reset mid-operation: rst=0 during the 2nd accumulate cycle of 3×5 → next edge all registers 0, ready=0, product=0. No accumulation takes effect on that edge.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants for the repeated-addition multiplier datapath and its control unit.
package mul_pkg;
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PROD_WIDTH = 2 * DEFAULT_WIDTH;

    // Register source selects; the CU drives these same encodings.
    localparam logic SEL_EXT  = 1'b0;
    localparam logic SEL_XCHG = 1'b1;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction
endpackage

// File: rtl/mul_datapath_dp_reg.sv
// Generic datapath register: synchronous active-low reset, clear over load, else hold.
module dp_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst)     q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= d;
    end
endmodule

// File: rtl/mul_datapath.sv
// Operand/counter/accumulator/result registers for the repeated-addition multiplier.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic                  L_R1,
    input  logic                  L_R2,
    input  logic                  L_R3,
    input  logic                  L_R4,
    input  logic                  R_R3,
    input  logic                  Dec_R1,
    input  logic                  Sel_R1,
    input  logic                  Sel_R2,
    input  logic                  S_R,
    input  logic                  R_R,
    output logic                  OR_R1,
    output logic                  CMP_L_R1,
    output logic [2*WIDTH-1:0]    product,
    output logic                  ready
);
    localparam int PW = prod_width(WIDTH);

    logic [WIDTH-1:0] r1, r2, r1_src, r2_src;
    logic [PW-1:0]    r3, r4, r3_sum;

    // Both muxes read pre-edge register values, so a double load with XCHG swaps R1/R2.
    assign r1_src = (Sel_R1 == SEL_XCHG) ? r2 : A;
    assign r2_src = (Sel_R2 == SEL_XCHG) ? r1 : B;
    assign r3_sum = r3 + {{(PW-WIDTH){1'b0}}, r2};

    always_ff @(posedge clk) begin
        if (!rst)                      r1 <= '0;
        else if (L_R1)                 r1 <= r1_src;
        else if (Dec_R1 && r1 != '0)   r1 <= r1 - WIDTH'(1);
    end

    dp_reg #(.W(WIDTH)) u_r2 (
        .clk(clk), .rst(rst), .clr(1'b0), .ld(L_R2), .d(r2_src), .q(r2)
    );

    dp_reg #(.W(PW)) u_r3 (
        .clk(clk), .rst(rst), .clr(R_R3), .ld(L_R3), .d(r3_sum), .q(r3)
    );

    dp_reg #(.W(PW)) u_r4 (
        .clk(clk), .rst(rst), .clr(1'b0), .ld(L_R4), .d(r3), .q(r4)
    );

    always_ff @(posedge clk) begin
        if (!rst)     ready <= 1'b0;
        else if (R_R) ready <= 1'b0;
        else if (S_R) ready <= 1'b1;
    end

    assign OR_R1    = |r1;
    assign CMP_L_R1 = (r1 <= r2);
    assign product  = r4;
endmodule
